// File: rtl/nibble_cpu_pkg.sv
// nibble_cpu shared definitions: opcodes, register selects, FSM states.
package nibble_cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_ST   = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_JZ   = 4'h7;
  localparam logic [3:0] OP_JC   = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] REG_A  = 2'd0;
  localparam logic [1:0] REG_X  = 2'd1;
  localparam logic [1:0] REG_Y  = 2'd2;
  localparam logic [1:0] REG_A2 = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH0,
    S_FETCH1,
    S_FETCH2,
    S_DECODE,
    S_LOAD,
    S_STORE,
    S_HALT
  } state_e;

  function automatic logic is_alu(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_ADD) ||
           (op == OP_AND) || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/nibble_cpu_alu.sv
// nibble_cpu ALU: LD/ADD/AND/XOR with zero and carry flags.
module nibble_cpu_alu
  import nibble_cpu_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              c_out
);

  always_comb begin
    result = a;
    c_out  = c_in;
    case (op)
      OP_LD:  result = b;
      OP_ADD: {c_out, result} = {1'b0, a} + {1'b0, b};
      OP_AND: begin
        result = a & b;
        c_out  = 1'b0;
      end
      OP_XOR: begin
        result = a ^ b;
        c_out  = 1'b0;
      end
      default: ;
    endcase
    z = (result == '0);
  end

endmodule

// File: rtl/nibble_cpu_core.sv
// nibble_cpu core: three-word fetch, stallable memory bus, Z/C flags.
// Build option: define TRACE_EN for the retire_valid/retire_pc trace port.
module nibble_cpu_core
  import nibble_cpu_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_space,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              retire_valid,
  output logic [ADDR_W-3:0] retire_pc
);

  localparam int PC_W = ADDR_W - 2;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] a_q, a_d, x_q, x_d, y_q, y_d;
  logic [DATA_W-1:0] w2_q, w2_d;
  logic [3:0]        w0_q, w0_d;
  logic [2:0]        w1_q, w1_d;
  logic              z_q, z_d, c_q, c_d;

  logic              req_c, we_c, space_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] sel_val, alu_b, alu_res;
  logic              alu_z, alu_c, wr_en, taken;

  always_comb begin
    case (w1_q[1:0])
      REG_X:   sel_val = x_q;
      REG_Y:   sel_val = y_q;
      default: sel_val = a_q;
    endcase
  end

  assign alu_b = (state_q == S_LOAD) ? mem_rdata : w2_q;

  nibble_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (w0_q),
    .a      (sel_val),
    .b      (alu_b),
    .c_in   (c_q),
    .result (alu_res),
    .z      (alu_z),
    .c_out  (alu_c)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    c_d     = c_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    req_c   = 1'b0;
    we_c    = 1'b0;
    space_c = 1'b0;
    addr_c  = '0;
    wdata_c = '0;
    wr_en   = 1'b0;
    taken   = 1'b0;
    unique case (state_q)
      S_FETCH0: begin
        req_c  = 1'b1;
        addr_c = {pc_q, 2'd0};
        if (mem_ready) begin
          w0_d    = mem_rdata[3:0];
          state_d = S_FETCH1;
        end
      end
      S_FETCH1: begin
        req_c  = 1'b1;
        addr_c = {pc_q, 2'd1};
        if (mem_ready) begin
          w1_d    = mem_rdata[2:0];
          state_d = S_FETCH2;
        end
      end
      S_FETCH2: begin
        req_c  = 1'b1;
        addr_c = {pc_q, 2'd2};
        if (mem_ready) begin
          w2_d    = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (w0_q)
          OP_JMP:  taken = 1'b1;
          OP_JZ:   taken = z_q;
          OP_JC:   taken = c_q;
          default: taken = 1'b0;
        endcase
        pc_d    = taken ? PC_W'(w2_q) : pc_q + PC_W'(1);
        state_d = S_FETCH0;
        if (w0_q == OP_ST) begin
          state_d = S_STORE;
        end else if (is_alu(w0_q)) begin
          if (w1_q[2]) wr_en = 1'b1;
          else         state_d = S_LOAD;
        end else if (w0_q == OP_HALT) begin
          state_d = S_HALT;
        end
      end
      S_LOAD: begin
        req_c   = 1'b1;
        space_c = 1'b1;
        addr_c  = ADDR_W'(w2_q);
        if (mem_ready) begin
          wr_en   = 1'b1;
          state_d = S_FETCH0;
        end
      end
      S_STORE: begin
        req_c   = 1'b1;
        we_c    = 1'b1;
        space_c = 1'b1;
        addr_c  = ADDR_W'(w2_q);
        wdata_c = sel_val;
        if (mem_ready) state_d = S_FETCH0;
      end
      S_HALT: ;
      default: state_d = S_FETCH0;
    endcase
    if (wr_en) begin
      case (w1_q[1:0])
        REG_X:   x_d = alu_res;
        REG_Y:   y_d = alu_res;
        default: a_d = alu_res;
      endcase
      z_d = alu_z;
      c_d = alu_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH0;
      pc_q    <= '0;
      a_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      w0_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      c_q     <= c_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
    end
  end

  // Reset abandons any in-flight access by gating the bus off.
  assign mem_req   = req_c & ~rst;
  assign mem_we    = we_c & ~rst;
  assign mem_space = space_c & ~rst;
  assign mem_addr  = rst ? '0 : addr_c;
  assign mem_wdata = rst ? '0 : wdata_c;
  assign halted    = (state_q == S_HALT) & ~rst;

`ifdef TRACE_EN
  logic [PC_W-1:0] ipc_q, ipc_d;
  logic            ret_c;

  // LOAD/STORE retire after pc has advanced, so keep the issuing PC.
  always_comb begin
    ipc_d = ipc_q;
    if (state_q == S_DECODE) ipc_d = pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) ipc_q <= '0;
    else     ipc_q <= ipc_d;
  end

  always_comb begin
    ret_c = 1'b0;
    if (state_q == S_DECODE)
      ret_c = (state_d == S_FETCH0) || (state_d == S_HALT);
    else if ((state_q == S_LOAD) || (state_q == S_STORE))
      ret_c = mem_ready;
  end

  assign retire_valid = ret_c & ~rst;
  assign retire_pc    = ~retire_valid ? '0 :
                        (state_q == S_DECODE) ? pc_q : ipc_q;
`else
  assign retire_valid = 1'b0;
  assign retire_pc    = '0;
`endif

endmodule

// File: tb/tb_nibble_cpu_core.sv
// Directed bench for nibble_cpu_core (DATA_W=4, ADDR_W=10).
module tb_nibble_cpu_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_req, mem_we, mem_space;
  logic [9:0] mem_addr;
  logic [3:0] mem_wdata, mem_rdata;
  logic       mem_ready;
  logic       halted, retire_valid;
  logic [7:0] retire_pc;

  logic [3:0] prog [1024];
  logic [3:0] dmem [16];
  int         wcount = 0;
  int         rcount = 0;
  logic [7:0] rpc [3];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  nibble_cpu_core #(.DATA_W(4), .ADDR_W(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_space    (mem_space),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .halted       (halted),
    .retire_valid (retire_valid),
    .retire_pc    (retire_pc)
  );

  assign mem_rdata = mem_space ? dmem[mem_addr[3:0]] : prog[mem_addr];

  always @(posedge clk) begin
    if (mem_req && mem_we && mem_ready) begin
      dmem[mem_addr[3:0]] <= mem_wdata;
      wcount <= wcount + 1;
    end
    if (retire_valid) begin
      if (rcount < 3) rpc[rcount] <= retire_pc;
      rcount <= rcount + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int pc, input logic [3:0] w0,
                     input logic [3:0] w1, input logic [3:0] w2);
    prog[pc*4]     = w0;
    prog[pc*4 + 1] = w1;
    prog[pc*4 + 2] = w2;
  endtask

  task automatic next_f0(input string tag, input int exp);
    int n = 1;
    @(negedge clk);
    while (!(mem_req && !mem_space && mem_addr[1:0] == 2'd0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {21'd0, mem_req, mem_addr}, {21'd0, 1'b1, 10'(exp)});
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int w0;
    int n;
    for (int i = 0; i < 1024; i++) prog[i] = 4'h0;
    for (int i = 0; i < 16; i++) dmem[i] = 4'h0;
    put(0,  4'h1, 4'h4, 4'h5);
    put(1,  4'h2, 4'h0, 4'h3);
    put(2,  4'h7, 4'h0, 4'h0);
    put(3,  4'h1, 4'h4, 4'hF);
    put(4,  4'h3, 4'h4, 4'h1);
    put(5,  4'h8, 4'h0, 4'h8);
    put(8,  4'h2, 4'h0, 4'h2);
    put(9,  4'h1, 4'h5, 4'h7);
    put(10, 4'h2, 4'h1, 4'h9);
    put(11, 4'h1, 4'h2, 4'h9);
    put(12, 4'h5, 4'h6, 4'h7);
    put(13, 4'h7, 4'h0, 4'hF);
    put(15, 4'h2, 4'h2, 4'h1);

    rst       = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("rst_outs", {mem_req, mem_we, halted, mem_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("fetch0_pc0", {mem_req, mem_space, mem_addr}, {1'b1, 1'b0, 10'd0});
    skip(1);
    chk("fetch1_pc0", mem_addr, 1);
    skip(1);
    chk("fetch2_pc0", mem_addr, 2);
    skip(1);
    chk("decode_idle", mem_req, 0);
    skip(1);
    chk("fetch_pc1", {mem_req, mem_addr}, {1'b1, 10'd4});

    skip(4);
    chk("st_a_ctl", {mem_req, mem_we, mem_space}, 3'b111);
    chk("st_a_addr", mem_addr, 3);
    chk("st_a_data", mem_wdata, 5);

    next_f0("jz_fetch", 8);
    next_f0("jz_not_taken", 12);
    next_f0("add_fetch", 16);
    next_f0("jc_fetch", 20);
    next_f0("jc_taken", 32);
    skip(4);
    chk("add_wrap_a", {mem_we, mem_addr, mem_wdata}, {1'b1, 10'd2, 4'd0});

    next_f0("ldx_fetch", 36);
    next_f0("stx_fetch", 40);
    skip(4);
    mem_ready = 1'b0;
    w0 = wcount;
    for (int i = 0; i < 4; i++) begin
      chk("st_stall_hold",
          {mem_req, mem_we, mem_space, mem_addr, mem_wdata},
          {1'b1, 1'b1, 1'b1, 10'd9, 4'd7});
      chk("st_stall_nowr", wcount, w0);
      if (i == 3) mem_ready = 1'b1;
      @(negedge clk);
    end
    chk("st_one_write", wcount, w0 + 1);
    chk("st_mem9", dmem[9], 7);
    chk("after_st", {mem_req, mem_addr}, {1'b1, 10'd44});

    skip(4);
    chk("ld_mem_req", {mem_req, mem_we, mem_space, mem_addr},
        {1'b1, 1'b0, 1'b1, 10'd9});
    next_f0("xor_fetch", 48);
    next_f0("jz2_fetch", 52);
    next_f0("jz_taken", 60);
    skip(4);
    chk("xor_zero_y", {mem_we, mem_addr, mem_wdata}, {1'b1, 10'd1, 4'd0});

    put(0, 4'hF, 4'h0, 4'h0);
    n = 0;
    while (!(mem_req && !mem_space && mem_addr == 10'd1020) && n < 1500) begin
      @(negedge clk);
      n++;
    end
    chk("reach_pc255", n < 1500, 1);
    next_f0("pc_wrap", 0);
    skip(4);
    for (int i = 0; i < 20; i++) begin
      chk("halt_hold", {halted, mem_req}, 2'b10);
      @(negedge clk);
    end

    rst = 1'b1;
    put(0, 4'h1, 4'h4, 4'h5);
    #1;
    chk("rst_gate", {halted, mem_req, mem_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("resume", {halted, mem_req, mem_addr}, {1'b0, 1'b1, 10'd0});

`ifdef TRACE_EN
    chk("retire_pc0", rpc[0], 0);
    chk("retire_pc1", rpc[1], 1);
    chk("retire_pc2", rpc[2], 2);
`else
    chk("retire_idle", rcount, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
